regfile_wb_arbiter: RTL and testbench
=====================================

Name: regfile_wb_arbiter

Overview:
- Shares the single register-file write port between two writeback sources: ALU results and memory-load results.
- Tracks outstanding destination registers in a pending-write scoreboard, and stalls issue on read-after-write or write-after-write hazards.
- Redirects writes to address 15 (PC slot; reads of it return PC+8) to a separate PC-write output; the register file never receives them.
- Sits between execute/memory stages and the register file write port; the stall output feeds the decode stage.

Parameters:
DATA_W, 32, writeback data width
ADDR_W, 4, register address width
STARVE_MAX, 3, consecutive lost cycles after which ALU overrides memory priority (1..7)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
issue_valid  in  1  decode issuing an instruction that writes issue_addr
issue_addr  in  ADDR_W  destination of issuing instruction
rd_addr1  in  ADDR_W  source register 1 of issuing instruction
rd_addr2  in  ADDR_W  source register 2 of issuing instruction
stall  out  1  issue blocked this cycle (combinational)
alu_valid  in  1  ALU writeback request
alu_addr  in  ADDR_W  ALU destination
alu_data  in  DATA_W  ALU result
alu_ready  out  1  ALU request granted this cycle (combinational)
mem_valid  in  1  load writeback request
mem_addr  in  ADDR_W  load destination
mem_data  in  DATA_W  load data
mem_ready  out  1  load request granted this cycle (combinational)
rf_we  out  1  register file write enable (registered)
rf_waddr  out  ADDR_W  register file write address (registered)
rf_wdata  out  DATA_W  register file write data (registered)
pc_we  out  1  PC write strobe (registered)
pc_wdata  out  DATA_W  PC write data (registered)
pending  out  15  scoreboard bit per register 0..14

Behaviour:
- Reset (async): rf_we=0, rf_waddr=0, rf_wdata=0, pc_we=0, pc_wdata=0, pending=0, starve counter=0.
- While reset is high, alu_ready=0 and mem_ready=0.
- If reset asserts while a write is registered, that write is dropped.
- Handshake: a source holds valid/addr/data stable until ready=1. A transfer occurs on the edge where valid&ready=1.
- At most one grant per cycle. The ready of a non-valid source is 0.
- Arbitration:
  - Memory has priority by default.
  - ALU wins when alu_valid=1 and starve==STARVE_MAX.
  - ALU also wins when mem_valid=0.
- Starve counter (3 bits):
  - Increments on cycles with alu_valid=1 and alu_ready=0, saturating at STARVE_MAX.
  - Clears on an ALU grant, or when alu_valid=0.
- Latency: 1 cycle. A grant at edge N produces rf_we or pc_we=1 during cycle N+1 with the granted addr/data.
- With no grant, rf_we=0 and pc_we=0 in the next cycle, and address/data hold their last value.
- Address 15: a granted write with addr==15 asserts pc_we=1 with pc_wdata=data, and leaves rf_we=0. No scoreboard effect.
- Scoreboard:
  - pending[a] (a<15) is set at the edge where issue_valid=1, stall=0 and issue_addr==a.
  - pending[a] is cleared at the end of the cycle in which rf_we=1 with rf_waddr==a, i.e. when the register file performs the write.
  - Set and clear of the same address on the same edge: set wins.
- stall = issue_valid & (hit(rd_addr1) | hit(rd_addr2) | hit(issue_addr)), where hit(x) = (x!=15) & pending[x].
  - Address 15 never hits.
  - Blocking on issue_addr prevents overlapping writes to one register, so a single bit per register suffices.
- No internal state machine beyond the registered write stage, the starve counter and the scoreboard.
- A grant never depends on rf_we, so back-to-back writes sustain 1 per cycle.

Test Plan:
- Reset with pending bits set, then deassert → all outputs 0. alu_valid=1 alone the next cycle → alu_ready=1, and rf_we=1 one cycle later with ALU addr/data.
- alu_valid and mem_valid held high with distinct addrs, STARVE_MAX=3 → mem granted 3 cycles, ALU granted on the 4th, then mem again. rf_we stays high every cycle.
- Issue addr 5 → pending[5]=1. Issue reading rd_addr1=5 → stall=1. ALU writes r5 → pending[5] clears after the rf_we cycle and stall drops the next cycle.
- mem writes addr 15, data 0x0000_0100 → pc_we=1, pc_wdata=0x100, rf_we=0, pending unchanged. An issue reading r15 never stalls.
- Issue to addr 3 on the same edge that rf_we commits an earlier r3 write with no stall → pending[3]=1 after the edge.
- Reset pulsed mid-cycle while rf_we=1 → rf_we drops immediately (async), and the dropped write never appears.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter for the single register-file write port: ALU vs load results,
// pending-write scoreboard with issue stall, and redirection of r15 writes to the PC.
module regfile_wb_arbiter #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned ADDR_W     = 4,
    parameter int unsigned STARVE_MAX = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              issue_valid,
    input  logic [ADDR_W-1:0] issue_addr,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    output logic              stall,
    input  logic              alu_valid,
    input  logic [ADDR_W-1:0] alu_addr,
    input  logic [DATA_W-1:0] alu_data,
    output logic              alu_ready,
    input  logic              mem_valid,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_data,
    output logic              mem_ready,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              pc_we,
    output logic [DATA_W-1:0] pc_wdata,
    output logic [14:0]       pending
);

    localparam logic [ADDR_W-1:0] PcAddr  = ADDR_W'(15);
    localparam int unsigned       NumAddr = 2 ** ADDR_W;

    logic [2:0]         starve_q, starve_d;
    logic [14:0]        pending_q, pending_d;
    logic [14:0]        set_vec, clr_vec;
    logic [NumAddr-1:0] pend_ext;
    logic               hit1, hit2, hit3;
    logic               alu_win, wb_any, wb_pc;
    logic [ADDR_W-1:0]  wb_addr;
    logic [DATA_W-1:0]  wb_data;

    // The PC slot has no scoreboard bit; zero-extend so any address indexes safely.
    assign pend_ext = {{(NumAddr - 15){1'b0}}, pending_q};

    assign hit1  = (rd_addr1 != PcAddr) & pend_ext[rd_addr1];
    assign hit2  = (rd_addr2 != PcAddr) & pend_ext[rd_addr2];
    assign hit3  = (issue_addr != PcAddr) & pend_ext[issue_addr];
    assign stall = issue_valid & (hit1 | hit2 | hit3);

    assign alu_win   = alu_valid & (~mem_valid | (starve_q == 3'(STARVE_MAX)));
    assign alu_ready = ~reset & alu_win;
    assign mem_ready = ~reset & mem_valid & ~alu_win;

    assign wb_any  = alu_ready | mem_ready;
    assign wb_addr = alu_ready ? alu_addr : mem_addr;
    assign wb_data = alu_ready ? alu_data : mem_data;
    assign wb_pc   = wb_addr == PcAddr;

    // A shift to bit 15 falls off the 15-bit vector, so r15 never touches the scoreboard.
    assign set_vec   = (issue_valid & ~stall) ? (15'(1) << issue_addr) : '0;
    assign clr_vec   = rf_we ? (15'(1) << rf_waddr) : '0;
    assign pending_d = (pending_q & ~clr_vec) | set_vec;
    assign pending   = pending_q;

    always_comb begin
        starve_d = starve_q;
        if (!alu_valid || alu_ready) begin
            starve_d = '0;
        end else if (starve_q != 3'(STARVE_MAX)) begin
            starve_d = starve_q + 3'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_q  <= '0;
            pending_q <= '0;
            rf_we     <= 1'b0;
            rf_waddr  <= '0;
            rf_wdata  <= '0;
            pc_we     <= 1'b0;
            pc_wdata  <= '0;
        end else begin
            starve_q  <= starve_d;
            pending_q <= pending_d;
            rf_we     <= wb_any & ~wb_pc;
            pc_we     <= wb_any & wb_pc;
            if (wb_any && !wb_pc) begin
                rf_waddr <= wb_addr;
                rf_wdata <= wb_data;
            end
            if (wb_any && wb_pc) begin
                pc_wdata <= wb_data;
            end
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench: directed scenarios with literal expectations plus randomized
// traffic compared every cycle against a behavioural model of the arbiter.
module tb_regfile_wb_arbiter;

    localparam int DW = 32;
    localparam int AW = 4;
    localparam int SM = 3;

    logic          clk;
    logic          reset;
    logic          issue_valid;
    logic [AW-1:0] issue_addr, rd_addr1, rd_addr2;
    logic          stall;
    logic          alu_valid, alu_ready;
    logic [AW-1:0] alu_addr;
    logic [DW-1:0] alu_data;
    logic          mem_valid, mem_ready;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_data;
    logic          rf_we, pc_we;
    logic [AW-1:0] rf_waddr;
    logic [DW-1:0] rf_wdata, pc_wdata;
    logic [14:0]   pending;

    regfile_wb_arbiter #(.DATA_W(DW), .ADDR_W(AW), .STARVE_MAX(SM)) dut (
        .clk        (clk),
        .reset      (reset),
        .issue_valid(issue_valid),
        .issue_addr (issue_addr),
        .rd_addr1   (rd_addr1),
        .rd_addr2   (rd_addr2),
        .stall      (stall),
        .alu_valid  (alu_valid),
        .alu_addr   (alu_addr),
        .alu_data   (alu_data),
        .alu_ready  (alu_ready),
        .mem_valid  (mem_valid),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .mem_ready  (mem_ready),
        .rf_we      (rf_we),
        .rf_waddr   (rf_waddr),
        .rf_wdata   (rf_wdata),
        .pc_we      (pc_we),
        .pc_wdata   (pc_wdata),
        .pending    (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: which registers await a write, how many cycles in a row the ALU
    // has been refused, and what the write port must show in the current cycle.
    bit          m_pend[15];
    int          m_lost;
    logic        m_rf_we, m_pc_we;
    logic [3:0]  m_rf_waddr;
    logic [31:0] m_rf_wdata, m_pc_wdata;
    bit          n_pend[15];
    int          n_lost;
    logic        n_rf_we, n_pc_we;
    logic [3:0]  n_rf_waddr;
    logic [31:0] n_rf_wdata, n_pc_wdata;

    function automatic logic [14:0] pend_vec();
        logic [14:0] v;
        for (int i = 0; i < 15; i++) v[i] = m_pend[i];
        return v;
    endfunction

    function automatic bit busy(input logic [3:0] x);
        return (x != 4'd15) ? m_pend[x] : 1'b0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 15; i++) m_pend[i] = 1'b0;
        m_lost = 0;
        m_rf_we = 1'b0; m_pc_we = 1'b0;
        m_rf_waddr = '0; m_rf_wdata = '0; m_pc_wdata = '0;
        n_pend = m_pend;
        n_lost = 0;
        n_rf_we = 1'b0; n_pc_we = 1'b0;
        n_rf_waddr = '0; n_rf_wdata = '0; n_pc_wdata = '0;
    endtask

    // Compare process: every cycle, check DUT against the model, then advance the model.
    initial begin
        bit          ea, em, es;
        logic [3:0]  a;
        logic [31:0] d;
        model_reset();
        forever begin
            @(negedge clk);
            if (reset) begin
                model_reset();
                chk("m_ready_in_reset", 32'({alu_ready, mem_ready}), 32'd0);
                chk("m_regs_in_reset", 32'({rf_we, pc_we, pending}), 32'd0);
            end else begin
                ea = alu_valid && (!mem_valid || m_lost == SM);
                em = mem_valid && !ea;
                es = issue_valid && (busy(rd_addr1) || busy(rd_addr2) || busy(issue_addr));
                chk("m_alu_ready", 32'(alu_ready), 32'(ea));
                chk("m_mem_ready", 32'(mem_ready), 32'(em));
                chk("m_stall", 32'(stall), 32'(es));
                chk("m_rf_we", 32'(rf_we), 32'(m_rf_we));
                chk("m_rf_waddr", 32'(rf_waddr), 32'(m_rf_waddr));
                chk("m_rf_wdata", rf_wdata, m_rf_wdata);
                chk("m_pc_we", 32'(pc_we), 32'(m_pc_we));
                chk("m_pc_wdata", pc_wdata, m_pc_wdata);
                chk("m_pending", 32'(pending), 32'(pend_vec()));

                n_rf_we = 1'b0; n_pc_we = 1'b0;
                n_rf_waddr = m_rf_waddr; n_rf_wdata = m_rf_wdata; n_pc_wdata = m_pc_wdata;
                if (ea || em) begin
                    a = ea ? alu_addr : mem_addr;
                    d = ea ? alu_data : mem_data;
                    if (a == 4'd15) begin
                        n_pc_we = 1'b1; n_pc_wdata = d;
                    end else begin
                        n_rf_we = 1'b1; n_rf_waddr = a; n_rf_wdata = d;
                    end
                end
                n_pend = m_pend;
                if (m_rf_we) n_pend[m_rf_waddr] = 1'b0;
                if (issue_valid && !es && issue_addr != 4'd15) n_pend[issue_addr] = 1'b1;
                n_lost = (alu_valid && !ea) ? ((m_lost + 1 > SM) ? SM : m_lost + 1) : 0;
            end
            @(posedge clk);
            if (reset) begin
                model_reset();
            end else begin
                m_pend = n_pend; m_lost = n_lost;
                m_rf_we = n_rf_we; m_rf_waddr = n_rf_waddr; m_rf_wdata = n_rf_wdata;
                m_pc_we = n_pc_we; m_pc_wdata = n_pc_wdata;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    initial begin
        bit ag, mg, exp_alu;
        reset = 1'b1;
        issue_valid = 1'b0; issue_addr = '0; rd_addr1 = '0; rd_addr2 = '0;
        alu_valid = 1'b0; alu_addr = '0; alu_data = '0;
        mem_valid = 1'b0; mem_addr = '0; mem_data = '0;
        step(); step();
        reset = 1'b0;
        issue_valid = 1'b1; issue_addr = 4'd7;
        at_neg(); chk("issue7_no_stall", 32'(stall), 32'd0);
        step(); issue_valid = 1'b0;
        at_neg(); chk("pending7_set", 32'(pending), 32'h0080);
        step(); reset = 1'b1;
        #1 chk("pending_async_clear", 32'(pending), 32'd0);
        step(); reset = 1'b0;
        at_neg();
        chk("reset_rf_we", 32'(rf_we), 32'd0);
        chk("reset_pc_we", 32'(pc_we), 32'd0);
        chk("reset_rf_wdata", rf_wdata, 32'd0);
        chk("reset_pending", 32'(pending), 32'd0);

        // ALU alone is granted at once and lands one cycle later.
        step(); alu_valid = 1'b1; alu_addr = 4'd2; alu_data = 32'h1234_5678;
        at_neg();
        chk("alu_alone_ready", 32'(alu_ready), 32'd1);
        chk("alu_alone_mem_ready", 32'(mem_ready), 32'd0);
        step(); alu_valid = 1'b0;
        at_neg();
        chk("alu_wb_we", 32'(rf_we), 32'd1);
        chk("alu_wb_addr", 32'(rf_waddr), 32'd2);
        chk("alu_wb_data", rf_wdata, 32'h1234_5678);

        // Both held: mem, mem, mem, alu, mem; write port busy every cycle.
        step();
        alu_valid = 1'b1; alu_addr = 4'd6; alu_data = 32'hBBBB_0006;
        mem_valid = 1'b1; mem_addr = 4'd4; mem_data = 32'hAAAA_0004;
        for (int i = 0; i < 5; i++) begin
            at_neg();
            exp_alu = (i == 3);
            chk("starve_alu_ready", 32'(alu_ready), 32'(exp_alu));
            chk("starve_mem_ready", 32'(mem_ready), 32'(!exp_alu));
            if (i > 0) begin
                chk("starve_rf_we", 32'(rf_we), 32'd1);
                chk("starve_rf_waddr", 32'(rf_waddr), (i == 4) ? 32'd6 : 32'd4);
            end
            step();
        end
        alu_valid = 1'b0; mem_valid = 1'b0;
        at_neg();
        chk("starve_last_addr", 32'(rf_waddr), 32'd4);

        // RAW hazard on r5 resolved by an ALU write.
        step(); issue_valid = 1'b1; issue_addr = 4'd5;
        at_neg(); chk("issue5_no_stall", 32'(stall), 32'd0);
        step(); issue_addr = 4'd9; rd_addr1 = 4'd5;
        at_neg();
        chk("raw_stall", 32'(stall), 32'd1);
        chk("pending5", 32'(pending), 32'h0020);
        step(); alu_valid = 1'b1; alu_addr = 4'd5; alu_data = 32'h0000_0055;
        at_neg();
        chk("r5_alu_ready", 32'(alu_ready), 32'd1);
        chk("raw_stall_grant", 32'(stall), 32'd1);
        step(); alu_valid = 1'b0;
        at_neg();
        chk("r5_rf_we", 32'(rf_we), 32'd1);
        chk("raw_stall_wb_cycle", 32'(stall), 32'd1);
        step();
        at_neg();
        chk("pending5_cleared", 32'(pending), 32'd0);
        chk("stall_dropped", 32'(stall), 32'd0);
        step(); issue_valid = 1'b0; rd_addr1 = 4'd0;
        at_neg(); chk("pending9", 32'(pending), 32'h0200);

        // r15 goes to the PC, never the register file or scoreboard.
        step(); mem_valid = 1'b1; mem_addr = 4'd15; mem_data = 32'h0000_0100;
        at_neg(); chk("pc_mem_ready", 32'(mem_ready), 32'd1);
        step();
        mem_valid = 1'b0;
        issue_valid = 1'b1; issue_addr = 4'd15; rd_addr1 = 4'd15; rd_addr2 = 4'd15;
        at_neg();
        chk("pc_we", 32'(pc_we), 32'd1);
        chk("pc_wdata", pc_wdata, 32'h0000_0100);
        chk("pc_rf_we", 32'(rf_we), 32'd0);
        chk("pc_pending", 32'(pending), 32'h0200);
        chk("r15_no_stall", 32'(stall), 32'd0);
        step(); issue_valid = 1'b0; issue_addr = '0; rd_addr1 = '0; rd_addr2 = '0;
        at_neg(); chk("r15_not_pending", 32'(pending), 32'h0200);

        // Issue to r3 on the edge that commits an r3 write: set wins.
        step(); alu_valid = 1'b1; alu_addr = 4'd3; alu_data = 32'h0000_0033;
        at_neg(); chk("r3_alu_ready", 32'(alu_ready), 32'd1);
        step(); alu_valid = 1'b0; issue_valid = 1'b1; issue_addr = 4'd3;
        at_neg();
        chk("r3_rf_we", 32'(rf_we), 32'd1);
        chk("r3_no_stall", 32'(stall), 32'd0);
        step(); issue_valid = 1'b0;
        at_neg(); chk("r3_set_wins", 32'(pending), 32'h0208);

        // Async reset while a write is on the port drops it.
        step(); alu_valid = 1'b1; alu_addr = 4'd8; alu_data = 32'h0000_0088;
        at_neg(); chk("r8_alu_ready", 32'(alu_ready), 32'd1);
        step(); alu_valid = 1'b0;
        chk("r8_rf_we_before_reset", 32'(rf_we), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("midreset_rf_we", 32'(rf_we), 32'd0);
        chk("midreset_rf_waddr", 32'(rf_waddr), 32'd0);
        step(); reset = 1'b0;
        at_neg();
        chk("dropped_rf_we", 32'(rf_we), 32'd0);
        chk("dropped_rf_wdata", rf_wdata, 32'd0);

        // Randomized traffic; sources hold requests until granted.
        for (int c = 0; c < 3000; c++) begin
            at_neg();
            ag = alu_ready; mg = mem_ready;
            step();
            if (reset) reset = 1'b0;
            else if ($urandom_range(0, 299) == 0) reset = 1'b1;
            if (!alu_valid || ag) begin
                alu_valid = ($urandom_range(0, 9) < 6);
                alu_addr = 4'($urandom_range(0, 15));
                alu_data = $urandom;
            end
            if (!mem_valid || mg) begin
                mem_valid = ($urandom_range(0, 9) < 6);
                mem_addr = 4'($urandom_range(0, 15));
                mem_data = $urandom;
            end
            issue_valid = 1'($urandom_range(0, 1));
            issue_addr = 4'($urandom_range(0, 15));
            rd_addr1 = 4'($urandom_range(0, 15));
            rd_addr2 = 4'($urandom_range(0, 15));
        end
        at_neg();
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
